onehot_rr_arbiter: RTL and testbench
====================================

Name: onehot_rr_arbiter

Overview:
- Upstream stage of the 8-to-3 encoder.
- Captures up to eight asynchronous-in-time request lines into a pending register and selects one request at a time by round-robin.
- Presents the selected request as a registered one-hot grant vector with a valid/ready handshake. Downstream, the encoder turns the grant into a 3-bit index.
- Guarantees the encoder input is always exactly one-hot (when valid) or all-zero.

Parameters:
- N_REQ, 8, number of request lines; fixed at 8 to match the encoder; any other value is unsupported.
- PTR_W, 3, width of the round-robin pointer (log2 N_REQ).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  8  request pulses/levels; a 1 on bit k at a rising edge sets pending[k].
- grant_o  output  8  registered one-hot grant, feeds encoder inputs i0..i7; all-zero when grant_valid_o=0.
- grant_valid_o  output  1  grant_o holds a valid one-hot grant.
- grant_ready_i  input  1  downstream accepts grant_o this cycle.
- pending_o  output  8  current pending register (status/debug).
- ptr_o  output  3  current round-robin start index.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - pending=0, grant_o=0, grant_valid_o=0, ptr=0.
  - Holds while rst_n low; release takes effect at the first rising edge with rst_n=1.
  - Reset mid-handshake discards the outstanding grant and all pending requests.
- Pending update, each edge: pending_next = (pending & ~clr_mask) | req_i.
  - clr_mask = grant_o when grant_valid_o & grant_ready_i, else 0.
  - Set wins: a req_i bit asserted in the same cycle its grant is accepted stays pending.
- FSM states:
  - IDLE: grant_valid_o=0.
  - GRANT: grant_valid_o=1.
- IDLE -> GRANT when pending (registered, before this edge's req_i) is non-zero.
  - grant_o loads the first set bit of pending scanning ptr, ptr+1, ... wrapping 7->0.
  - Latency: req_i sampled at edge k -> pending at k -> grant_valid_o at edge k+1 (2 edges min).
- GRANT, grant_ready_i=0: grant_o and grant_valid_o hold stable. Required; no retraction, no change of index.
- GRANT, grant_ready_i=1 (accept):
  - ptr <= (granted index + 1) mod 8.
  - If (pending & ~grant_o) is non-zero, stay in GRANT and load the next grant in the same edge, scanning from the new ptr: back-to-back, no bubble.
  - Otherwise go to IDLE, grant_o <= 0.
- Wrap-around: granted index 7 -> ptr=0.
- Fairness: with all 8 pending and ready held high, grants cycle through all indices in 8 consecutive cycles.
- grant_o is never multi-hot. Bench asserts $onehot0(grant_o) every cycle and grant_o==0 iff !grant_valid_o.
- No overflow concept: a repeated request on an already pending bit is absorbed (single pending bit).

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest set index wins. ptr is unused and held at 0, ptr_o reads 0. All other handshake/pending rules unchanged.
- Undefined (default): round-robin as above.

Test Plan:
- Reset/idle: rst_n low 3 cycles, then req_i=0 -> grant_o=00000000, grant_valid_o=0, pending_o=0, ptr_o=0 throughout.
- Single request: req_i=00001000 one cycle, ready=1 -> grant_valid_o=1, grant_o=00001000 two edges later; accepted next edge; then ptr_o=4, pending_o=0, idle.
- Round-robin and wrap: ptr=6, pending=10000101, ready=1 -> grants in order 10000000, 00000001, 00000100 on consecutive cycles; final ptr_o=3.
- Backpressure: grant 00100000 valid, ready=0 for 5 cycles while req_i=00000010 -> grant_o stays 00100000; pending_o=00100010; after ready=1, next grant 00000010.
- Set-wins collision: grant 00000001 accepted in the same cycle req_i=00000001 -> pending_o bit0 stays 1; bit0 is re-granted after other pending bits (round-robin).
- Async reset mid-operation: grant_valid_o=1, pending=11110000, rst_n pulsed low between edges -> outputs zero immediately, before the next clock edge; no grant after release until new req_i.

Source files
------------

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: request capture and round-robin one-hot grant stage that
// feeds the 8-to-3 encoder. Requests are latched into a pending register, and
// one is presented at a time as a registered one-hot grant with valid/ready.
// Optional build macro ARB_FIXED_PRIO_EN selects fixed priority instead:
// the lowest set index wins, and the pointer is held at 0.
module onehot_rr_arbiter #(
    parameter int N_REQ = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             grant_valid_o,
    input  logic             grant_ready_i,
    output logic [N_REQ-1:0] pending_o,
    output logic [PTR_W-1:0] ptr_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] pending, pending_nxt;
    logic [N_REQ-1:0] grant, grant_nxt;
    logic [N_REQ-1:0] clr_mask, rest;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [PTR_W-1:0] grant_idx, idle_start, next_start;
    logic             accept;

    // Scan vec from start upward with wrap, returning the first set bit as one-hot.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] vec,
                                                 input logic [PTR_W-1:0] start);
        logic [N_REQ-1:0] sel;
        logic             found;
        logic [PTR_W-1:0] k;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = start + PTR_W'(i);
            if (!found && vec[k]) begin
                sel[k] = 1'b1;
                found  = 1'b1;
            end
        end
        return sel;
    endfunction

    // Encode the current one-hot grant into its index.
    always_comb begin
        grant_idx = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
        end
    end

    // Scan start points: the round-robin pointer, or index 0 for fixed priority.
    always_comb begin
`ifdef ARB_FIXED_PRIO_EN
        idle_start = '0;
        next_start = '0;
`else
        idle_start = ptr;
        next_start = grant_idx + PTR_W'(1);
`endif
    end

    // Pending update (set wins over clear) and next grant/state selection.
    always_comb begin
        accept      = (state == GRANT) && grant_ready_i;
        clr_mask    = accept ? grant : '0;
        pending_nxt = (pending & ~clr_mask) | req_i;
        rest        = pending & ~grant;
        state_nxt   = state;
        grant_nxt   = grant;
        ptr_nxt     = ptr;
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_nxt = GRANT;
                    grant_nxt = rr_pick(pending, idle_start);
                end
            end
            GRANT: begin
                if (grant_ready_i) begin
                    ptr_nxt = next_start;
                    if (|rest) begin
                        grant_nxt = rr_pick(rest, next_start);
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State, grant, pending and pointer registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            pending <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            pending <= pending_nxt;
            ptr     <= ptr_nxt;
        end
    end

    assign grant_o       = grant;
    assign grant_valid_o = (state == GRANT);
    assign pending_o     = pending;
    assign ptr_o         = ptr;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Testbench for onehot_rr_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against an index-based behavioural model.
module tb_onehot_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_i;
    logic [7:0] grant_o;
    logic       grant_valid_o;
    logic       grant_ready_i;
    logic [7:0] pending_o;
    logic [2:0] ptr_o;

    int total = 0;
    int bad   = 0;

    // Reference model state: a pending bit set, a granted index, a start index.
    bit [7:0] m_pend;
    bit       m_valid;
    int       m_idx;
    int       m_ptr;

    onehot_rr_arbiter #(.N_REQ(8), .PTR_W(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .grant_o       (grant_o),
        .grant_valid_o (grant_valid_o),
        .grant_ready_i (grant_ready_i),
        .pending_o     (pending_o),
        .ptr_o         (ptr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int scan(input bit [7:0] v, input int start);
        for (int k = 0; k < 8; k++) begin
            if (v[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    function automatic int first_start(input int p);
`ifdef ARB_FIXED_PRIO_EN
        return 0;
`else
        return p;
`endif
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
    endtask

    task automatic model_edge(input bit [7:0] req, input bit rdy);
        bit [7:0] nxt_pend;
        bit [7:0] rest;
        nxt_pend = m_pend;
        if (m_valid && rdy) nxt_pend[m_idx] = 1'b0;
        nxt_pend = nxt_pend | req;
        if (!m_valid) begin
            if (m_pend != 0) begin
                m_idx   = scan(m_pend, first_start(m_ptr));
                m_valid = 1'b1;
            end
        end else if (rdy) begin
            rest = m_pend;
            rest[m_idx] = 1'b0;
            m_ptr = first_start((m_idx + 1) % 8);
            if (rest != 0) m_idx = scan(rest, m_ptr);
            else m_valid = 1'b0;
        end
        m_pend = nxt_pend;
    endtask

    function automatic logic [7:0] m_grant();
        logic [7:0] g;
        g = '0;
        if (m_valid) g[m_idx] = 1'b1;
        return g;
    endfunction

    task automatic compare_all();
        check("grant", grant_o, m_grant());
        check("valid", grant_valid_o, m_valid);
        check("pending", pending_o, m_pend);
        check("ptr", ptr_o, m_ptr[2:0]);
        check("onehot0", 32'($onehot0(grant_o)), 1);
        check("zero_iff_idle", 32'(grant_o == 8'h00), 32'(!grant_valid_o));
    endtask

    // Apply inputs, take one rising edge, advance the model, then compare.
    task automatic cycle(input logic [7:0] req, input logic rdy);
        req_i         = req;
        grant_ready_i = rdy;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(req, rdy);
        #1;
        compare_all();
    endtask

    logic [7:0] seen;

    initial begin
        rst_n         = 1'b0;
        req_i         = '0;
        grant_ready_i = 1'b0;
        model_reset();

        // Reset held for three cycles, then idle with no requests.
        for (int i = 0; i < 3; i++) cycle(8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) cycle(8'h00, 1'b0);
        check("idle_grant", grant_o, 8'h00);
        check("idle_ptr", ptr_o, 3'd0);

        // Single request on bit 3.
        cycle(8'h08, 1'b1);
        check("single_no_grant_yet", grant_valid_o, 1'b0);
        cycle(8'h00, 1'b1);
        check("single_grant", grant_o, 8'h08);
        cycle(8'h00, 1'b1);
        check("single_ptr", ptr_o, 3'd4);
        check("single_pend", pending_o, 8'h00);
        check("single_idle", grant_valid_o, 1'b0);

        // Move ptr to 6, then round-robin with wrap over 10000101.
        cycle(8'h20, 1'b1);
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);
        check("rr_ptr6", ptr_o, 3'd6);
        cycle(8'h85, 1'b1);
        cycle(8'h00, 1'b1);
        check("rr_g0", grant_o, 8'h80);
        cycle(8'h00, 1'b1);
        check("rr_g1", grant_o, 8'h01);
        cycle(8'h00, 1'b1);
        check("rr_g2", grant_o, 8'h04);
        cycle(8'h00, 1'b1);
        check("rr_ptr3", ptr_o, 3'd3);
        check("rr_idle", grant_valid_o, 1'b0);

        // Backpressure: grant on bit 5 held while bit 1 arrives.
        cycle(8'h20, 1'b0);
        cycle(8'h00, 1'b0);
        check("bp_grant", grant_o, 8'h20);
        for (int i = 0; i < 5; i++) begin
            cycle(8'h02, 1'b0);
            check("bp_hold", grant_o, 8'h20);
        end
        check("bp_pend", pending_o, 8'h22);
        cycle(8'h00, 1'b1);
        check("bp_next", grant_o, 8'h02);
        cycle(8'h00, 1'b1);

        // Set-wins collision on bit 0.
        cycle(8'h01, 1'b0);
        cycle(8'h10, 1'b0);
        check("sw_grant0", grant_o, 8'h01);
        cycle(8'h01, 1'b1);
        check("sw_pend", pending_o, 8'h11);
        check("sw_next", grant_o, 8'h10);
        cycle(8'h00, 1'b1);
        check("sw_regrant", grant_o, 8'h01);
        cycle(8'h00, 1'b1);

        // Fairness: all eight pending, ready held high.
        cycle(8'hFF, 1'b1);
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            cycle(8'h00, 1'b1);
            seen = seen | grant_o;
        end
        check("fair_all", seen, 8'hFF);
        cycle(8'h00, 1'b1);

        // Asynchronous reset between edges while a grant is outstanding.
        cycle(8'hF0, 1'b0);
        cycle(8'h00, 1'b0);
        check("ar_valid_before", grant_valid_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        cycle(8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(8'h00, 1'b1);
            check("ar_no_grant", grant_valid_o, 1'b0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 2) != 0) r = r & 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            cycle(r, 1'($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
